// File: rtl/iiitb_alu.sv
// 4-bit, 16-operation ALU. The opcode selects one operation on operands A and B,
// and the result is registered on ALU_out with one cycle of latency.
module iiitb_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] instruction,
    output logic [3:0] ALU_out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_t;

    alu_op_t    op_s;
    logic [7:0] product_s;
    logic [3:0] quotient_s;
    logic [3:0] result_s;

    assign op_s = alu_op_t'(instruction);

    // Full 8-bit product is formed and then truncated to the low nibble.
    assign product_s = {4'b0000, A} * {4'b0000, B};

    // A zero divisor yields a zero quotient rather than an undefined value.
    always_comb begin
        quotient_s = 4'h0;
        if (B != 4'h0) begin
            quotient_s = A / B;
        end else begin
            quotient_s = 4'h0;
        end
    end

    // Combinational result selection.
    always_comb begin
        result_s = 4'h0;
        case (op_s)
            OP_ADD:  result_s = A + B;
            OP_SUB:  result_s = A - B;
            OP_MUL:  result_s = product_s[3:0];
            OP_DIV:  result_s = quotient_s;
            OP_SHL:  result_s = {A[2:0], 1'b0};
            OP_SHR:  result_s = {1'b0, A[3:1]};
            OP_ROL:  result_s = {A[2:0], A[3]};
            OP_ROR:  result_s = {A[0], A[3:1]};
            OP_AND:  result_s = A & B;
            OP_OR:   result_s = A | B;
            OP_XOR:  result_s = A ^ B;
            OP_NOR:  result_s = ~(A | B);
            OP_NAND: result_s = ~(A & B);
            OP_XNOR: result_s = ~(A ^ B);
            OP_GT:   result_s = (A > B) ? 4'h1 : 4'h0;
            OP_EQ:   result_s = (A == B) ? 4'h1 : 4'h0;
            default: result_s = 4'h0;
        endcase
    end

    // Output register; reset clears it immediately and drops any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_out <= 4'h0;
        end else begin
            ALU_out <= result_s;
        end
    end

endmodule

// File: tb/tb_iiitb_alu.sv
// Self-checking bench for iiitb_alu: directed vector table, reset/hold sequences,
// an opcode sweep and random stimulus against an integer reference model.
module tb_iiitb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] instruction;
    logic [3:0] alu_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [22];

    iiitb_alu dut (
        .clk         (clk),
        .rst         (rst),
        .A           (a),
        .B           (b),
        .instruction (instruction),
        .ALU_out     (alu_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model computed with plain integer arithmetic modulo 16.
    function automatic int model(input int x, input int y, input int op);
        case (op)
            0:  return (x + y) % 16;
            1:  return (x - y + 16) % 16;
            2:  return (x * y) % 16;
            3:  return (y == 0) ? 0 : x / y;
            4:  return (x * 2) % 16;
            5:  return x / 2;
            6:  return (x * 2) % 16 + x / 8;
            7:  return x / 2 + (x % 2) * 8;
            8:  return x & y;
            9:  return x | y;
            10: return x ^ y;
            11: return 15 - (x | y);
            12: return 15 - (x & y);
            13: return 15 - (x ^ y);
            14: return (x > y) ? 1 : 0;
            15: return (x == y) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vop);
        @(negedge clk);
        a = va;
        b = vb;
        instruction = vop;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'h7, 4'hA, 4'h0, 4'h1};
        tbl[1]  = '{4'h7, 4'hA, 4'h1, 4'hD};
        tbl[2]  = '{4'h7, 4'hA, 4'h2, 4'h6};
        tbl[3]  = '{4'h7, 4'hA, 4'h3, 4'h0};
        tbl[4]  = '{4'h7, 4'hA, 4'h4, 4'hE};
        tbl[5]  = '{4'h7, 4'hA, 4'h5, 4'h3};
        tbl[6]  = '{4'h7, 4'hA, 4'h6, 4'hE};
        tbl[7]  = '{4'h7, 4'hA, 4'h7, 4'hB};
        tbl[8]  = '{4'h9, 4'hA, 4'h7, 4'hC};
        tbl[9]  = '{4'h7, 4'hA, 4'h8, 4'h2};
        tbl[10] = '{4'h7, 4'hA, 4'h9, 4'hF};
        tbl[11] = '{4'h7, 4'hA, 4'hA, 4'hD};
        tbl[12] = '{4'h7, 4'hA, 4'hB, 4'h0};
        tbl[13] = '{4'h7, 4'hA, 4'hC, 4'hD};
        tbl[14] = '{4'h7, 4'hA, 4'hD, 4'h2};
        tbl[15] = '{4'h7, 4'hA, 4'hE, 4'h0};
        tbl[16] = '{4'h7, 4'hA, 4'hF, 4'h0};
        tbl[17] = '{4'hA, 4'h7, 4'hE, 4'h1};
        tbl[18] = '{4'h5, 4'h5, 4'hF, 4'h1};
        tbl[19] = '{4'hB, 4'h0, 4'h3, 4'h0};
        tbl[20] = '{4'hF, 4'hF, 4'h2, 4'h1};
        tbl[21] = '{4'h0, 4'h1, 4'h1, 4'hF};

        rst = 1'b1;
        a = 4'h7;
        b = 4'hA;
        instruction = 4'h9;
        #3;
        check("reset_initial", alu_out, 4'h0);
        @(posedge clk);
        #1;
        check("reset_held_edge", alu_out, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release_or", alu_out, 4'hF);

        // Asynchronous assertion mid-cycle
        #5;
        rst = 1'b1;
        #1;
        check("reset_async_immediate", alu_out, 4'h0);
        @(posedge clk);
        #1;
        check("reset_async_through_edge", alu_out, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_release_before_edge", alu_out, 4'h0);
        @(posedge clk);
        #1;
        check("reset_async_release", alu_out, 4'hF);

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].op);
            check($sformatf("vec%0d_op%0h", i, tbl[i].op), alu_out, tbl[i].exp);
        end

        // Second ADD corner not in the table: 0xF + 0xF
        apply(4'hF, 4'hF, 4'h0);
        check("add_ff", alu_out, 4'hE);

        // Hold: inputs change between edges, output must not move
        apply(4'h7, 4'hA, 4'h0);
        check("hold_before", alu_out, 4'h1);
        #4;
        a = 4'h3;
        instruction = 4'h2;
        #4;
        check("hold_mid_cycle", alu_out, 4'h1);
        @(posedge clk);
        #1;
        check("hold_after_edge", alu_out, 4'hE);

        // Opcode sweep 0x1..0xF then wrap to 0x0
        begin
            logic [3:0] sa;
            logic [3:0] sb;
            logic [3:0] op_v;
            sa = 4'($urandom_range(0, 15));
            sb = 4'($urandom_range(1, 15));
            for (int k = 1; k <= 16; k++) begin
                op_v = 4'(k % 16);
                apply(sa, sb, op_v);
                check($sformatf("sweep_op%0h", op_v), alu_out, 4'(model(int'(sa), int'(sb), int'(op_v))));
            end
        end

        // Random stimulus against the model
        for (int r = 0; r < 300; r++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [3:0] rop;
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 4'($urandom_range(0, 15));
            apply(ra, rb, rop);
            check($sformatf("rand%0d_a%0h_b%0h_op%0h", r, ra, rb, rop), alu_out,
                  4'(model(int'(ra), int'(rb), int'(rop))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
